alu_issue_unit: RTL and testbench

Operand-issue and write-back sequencer placed directly upstream of the 4-bit ALU. It accepts one instruction at a time over a valid/ready handshake and reads operands from a 4-entry × 4-bit register file. It drives the ALU's A, B and 3-bit control inputs, waits a fixed settle time for the ALU's ripple logic, then captures the ALU result. The result is written back to the register file and presented on a valid/ready result port.

---
 rtl/alu_issue_unit.sv | 161 ++++++++++++++++
 tb/tb_alu_issue_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_unit.sv
// alu_issue_unit
// Issues one instruction at a time to an external 4-bit ALU. Operands come
// from a 4 x 4-bit register file, or from an immediate for the B operand.
// The ALU inputs are held for SETTLE_CYCLES so its ripple logic can settle.
// The ALU result is then captured, written back to the register file and
// offered on a valid/ready result port.
//
// state | meaning
// IDLE  | ready for an instruction; operands are sampled on accept
// EXEC  | ALU inputs held, settle counter running
// RESP  | result presented, waiting for res_ready
module alu_issue_unit #(
    parameter int SETTLE_CYCLES = 2  // legal range 1..15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [2:0] instr_op,
    input  logic [1:0] instr_rd,
    input  logic [1:0] instr_ra,
    input  logic [1:0] instr_rb,
    input  logic       instr_imm_en,
    input  logic [3:0] instr_imm,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_ctrl,
    input  logic [3:0] alu_s,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_data,
    output logic       res_zero,
    output logic [1:0] res_rd,
    input  logic [1:0] dbg_addr,
    output logic [3:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
    // Reset value of the control output is the ADD code.
    localparam logic [2:0] CTRL_RESET  = 3'b010;

    state_t     state;
    state_t     state_next;
    logic [3:0] settle_cnt;
    logic [1:0] rd_q;
    logic [3:0] rf [4];

    logic accept;
    logic capture;
    logic res_done;

    assign accept   = instr_valid && (state == IDLE);
    // Capture on the edge where the down-counter would reach zero.
    assign capture  = (state == EXEC) && (settle_cnt == 4'd1);
    assign res_done = (state == RESP) && res_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (capture) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (res_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state; they are mutually exclusive by construction.
    always_comb begin
        instr_ready = 1'b0;
        res_valid   = 1'b0;
        case (state)
            IDLE:    instr_ready = 1'b1;
            RESP:    res_valid   = 1'b1;
            default: begin
                instr_ready = 1'b0;
                res_valid   = 1'b0;
            end
        endcase
    end

    // ALU operand/control registers, loaded only on accept and held otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a    <= 4'd0;
            alu_b    <= 4'd0;
            alu_ctrl <= CTRL_RESET;
            rd_q     <= 2'd0;
        end else if (accept) begin
            alu_a    <= rf[instr_ra];
            alu_b    <= instr_imm_en ? instr_imm : rf[instr_rb];
            alu_ctrl <= instr_op;
            rd_q     <= instr_rd;
        end
    end

    // Settle timer: loaded on accept, counts down while in EXEC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_cnt <= 4'd0;
        end else if (accept) begin
            settle_cnt <= SETTLE_LOAD;
        end else if ((state == EXEC) && !capture) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    // Result registers, captured once per instruction and held through RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_data <= 4'd0;
            res_zero <= 1'b1;
            res_rd   <= 2'd0;
        end else if (capture) begin
            res_data <= alu_s;
            res_zero <= (alu_s == 4'd0);
            res_rd   <= rd_q;
        end
    end

    // Register file write-back on the capture edge; reset clears every entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                rf[i] <= 4'd0;
            end
        end else if (capture) begin
            rf[rd_q] <= alu_s;
        end
    end

    assign dbg_data = rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: external ALU model, register-file model and a
// per-cycle compare process, driven by directed instruction vectors.
module tb_alu_issue_unit;

    localparam int S = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [2:0] instr_op = 3'd0;
    logic [1:0] instr_rd = 2'd0;
    logic [1:0] instr_ra = 2'd0;
    logic [1:0] instr_rb = 2'd0;
    logic       instr_imm_en = 1'b0;
    logic [3:0] instr_imm = 4'd0;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_ctrl;
    logic [3:0] alu_s;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic [3:0] res_data;
    logic       res_zero;
    logic [1:0] res_rd;
    logic [1:0] dbg_addr = 2'd0;
    logic [3:0] dbg_data;

    alu_issue_unit #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra),
        .instr_rb(instr_rb), .instr_imm_en(instr_imm_en), .instr_imm(instr_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_s(alu_s),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_zero(res_zero), .res_rd(res_rd),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [3:0] m_rf [4];
    logic [3:0] exp_a = 4'd0;
    logic [3:0] exp_b = 4'd0;
    logic [3:0] exp_data = 4'd0;
    logic [2:0] exp_op = 3'b010;
    logic [1:0] exp_rd = 2'd0;
    bit         busy = 1'b0;
    bit         prev_valid = 1'b0;

    function automatic logic [3:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            3'b000:  return 4'd0 - a;
            3'b001:  return 4'd0 - b;
            3'b010:  return a + b;
            3'b011:  return a - b;
            3'b100:  return a & b;
            3'b101:  return a | b;
            3'b110:  return 4'(a * b);
            default: return a ^ b;
        endcase
    endfunction

    always_comb alu_s = alu_ref(alu_ctrl, alu_a, alu_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) m_rf[i] = 4'd0;
            prev_valid = 1'b0;
            chk("rst_instr_ready", 32'(instr_ready), 32'd1);
            chk("rst_res_valid", 32'(res_valid), 32'd0);
            chk("rst_res_data", 32'(res_data), 32'd0);
            chk("rst_res_zero", 32'(res_zero), 32'd1);
            chk("rst_res_rd", 32'(res_rd), 32'd0);
            chk("rst_alu_a", 32'(alu_a), 32'd0);
            chk("rst_alu_b", 32'(alu_b), 32'd0);
            chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd2);
            chk("rst_dbg_data", 32'(dbg_data), 32'd0);
        end else begin
            chk("ready_valid_excl", 32'(instr_ready && res_valid), 32'd0);
            if (res_valid && !prev_valid) m_rf[exp_rd] = exp_data;
            prev_valid = res_valid;
            chk("dbg_data", 32'(dbg_data), 32'(m_rf[dbg_addr]));
            if (busy) begin
                chk("alu_a", 32'(alu_a), 32'(exp_a));
                chk("alu_b", 32'(alu_b), 32'(exp_b));
                chk("alu_ctrl", 32'(alu_ctrl), 32'(exp_op));
            end
            if (res_valid) begin
                chk("res_data", 32'(res_data), 32'(exp_data));
                chk("res_zero", 32'(res_zero), 32'(exp_data == 4'd0));
                chk("res_rd", 32'(res_rd), 32'(exp_rd));
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [1:0] ra, input logic [1:0] rb,
                         input logic ie, input logic [3:0] imm, input logic [1:0] rd,
                         input logic [3:0] lit, input int bp);
        int n;
        n = 0;
        while (!instr_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("issue_ready", 32'(instr_ready), 32'd1);
        busy     = 1'b0;
        exp_a    = m_rf[ra];
        exp_b    = ie ? imm : m_rf[rb];
        exp_op   = op;
        exp_rd   = rd;
        exp_data = alu_ref(op, exp_a, exp_b);
        chk("model_literal", 32'(exp_data), 32'(lit));
        instr_op = op; instr_ra = ra; instr_rb = rb;
        instr_imm_en = ie; instr_imm = imm; instr_rd = rd;
        instr_valid = 1'b1;
        dbg_addr = rd;
        if (bp > 0) res_ready = 1'b0;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        busy = 1'b1;
        n = 0;
        while (!res_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", 32'(n), 32'(S));
        chk("res_data_literal", 32'(res_data), 32'(lit));
        if (bp > 0) begin
            instr_valid = 1'b1;
            instr_op = ~op; instr_ra = ~ra; instr_imm_en = 1'b1;
            instr_imm = ~imm; instr_rd = ~rd;
            repeat (bp) begin
                @(posedge clk); #1;
                chk("bp_res_valid", 32'(res_valid), 32'd1);
                chk("bp_instr_ready", 32'(instr_ready), 32'd0);
                chk("bp_res_data", 32'(res_data), 32'(lit));
            end
            instr_valid = 1'b0;
            res_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("ready_after_hs", 32'(instr_ready), 32'd1);
        chk("valid_after_hs", 32'(res_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            dbg_addr = 2'(a);
            #1;
            chk("reset_sweep_dbg", 32'(dbg_data), 32'd0);
        end
        chk("reset_instr_ready", 32'(instr_ready), 32'd1);
        chk("reset_res_valid", 32'(res_valid), 32'd0);
        chk("reset_alu_ctrl", 32'(alu_ctrl), 32'd2);
        @(posedge clk); #1;

        // op    ra    rb    ie    imm    rd    expected  backpressure
        issue(3'b010, 2'd0, 2'd0, 1'b1, 4'd5,  2'd1, 4'd5,  0);
        chk("load_res_zero", 32'(res_zero), 32'd0);
        issue(3'b010, 2'd1, 2'd0, 1'b1, 4'd3,  2'd2, 4'd8,  0);
        dbg_addr = 2'd2; #1;
        chk("rf2_is_8", 32'(dbg_data), 32'd8);
        issue(3'b011, 2'd2, 2'd1, 1'b0, 4'd0,  2'd3, 4'd3,  0);
        issue(3'b011, 2'd1, 2'd1, 1'b0, 4'd0,  2'd0, 4'd0,  0);
        issue(3'b110, 2'd1, 2'd0, 1'b1, 4'd7,  2'd3, 4'd3,  0);
        issue(3'b000, 2'd1, 2'd0, 1'b1, 4'd0,  2'd2, 4'd11, 0);
        issue(3'b001, 2'd1, 2'd0, 1'b1, 4'd1,  2'd2, 4'd15, 0);
        issue(3'b100, 2'd1, 2'd0, 1'b1, 4'hC,  2'd3, 4'd4,  0);
        issue(3'b101, 2'd1, 2'd0, 1'b1, 4'hA,  2'd3, 4'hF,  0);
        issue(3'b111, 2'd1, 2'd0, 1'b1, 4'hF,  2'd3, 4'hA,  0);
        issue(3'b010, 2'd1, 2'd1, 1'b0, 4'd0,  2'd1, 4'd10, 0);
        issue(3'b010, 2'd1, 2'd0, 1'b1, 4'd1,  2'd0, 4'd11, 10);
        repeat (2) begin
            @(posedge clk); #1;
            chk("post_bp_idle", 32'(instr_ready), 32'd1);
        end

        // Abort mid-EXEC: accept, then reset one cycle later.
        busy = 1'b0;
        instr_op = 3'b010; instr_ra = 2'd0; instr_rb = 2'd0;
        instr_imm_en = 1'b1; instr_imm = 4'd9; instr_rd = 2'd2;
        dbg_addr = 2'd2;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        chk("abort_in_exec", 32'(instr_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (S + 3) begin
            @(posedge clk); #1;
            chk("abort_no_valid", 32'(res_valid), 32'd0);
            chk("abort_idle", 32'(instr_ready), 32'd1);
            chk("abort_rf2", 32'(dbg_data), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
